// File: rtl/memory_write_queue_pkg.sv
// -----------------------------------------------------------------------------
// g76_memory_pkg
// Shared constants and types for the host-to-memory-manager write queue.
//   ADDR_WIDTH / DATA_WIDTH : default widths of the memory manager write port
//   write_entry_t           : one queued write {addr, data}
//   write_queue_state_t     : issue FSM states (IDLE -> ISSUE -> RETIRE)
// -----------------------------------------------------------------------------
package g76_memory_pkg;

    localparam int ADDR_WIDTH = 17;
    localparam int DATA_WIDTH = 8;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
    } write_entry_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        RETIRE = 2'd2
    } write_queue_state_t;

endpackage

// File: rtl/memory_write_queue_if.sv
// -----------------------------------------------------------------------------
// memory_write_queue_if
// Bundles the host write handshake, the memory manager write port and the
// queue status signals of memory_write_queue.
//   master : the environment (host + memory manager) side
//   slave  : the queue side
// -----------------------------------------------------------------------------
interface memory_write_queue_if #(
    parameter int  DEPTH      = 8,
    parameter int  ADDR_WIDTH = g76_memory_pkg::ADDR_WIDTH,
    parameter int  DATA_WIDTH = g76_memory_pkg::DATA_WIDTH,
    localparam int LVL_WIDTH  = $clog2(DEPTH) + 1
);

    logic                  hostWriteValid;
    logic [ADDR_WIDTH-1:0] hostWriteAddress;
    logic [DATA_WIDTH-1:0] hostWriteData;
    logic                  hostWriteReady;
    logic                  memoryWriteRequest;
    logic [ADDR_WIDTH-1:0] memoryWriteAddress;
    logic [DATA_WIDTH-1:0] memoryWriteData;
    logic                  memoryWriteComplete;
    logic [LVL_WIDTH-1:0]  queueLevel;
    logic                  queueEmpty;

    modport master (
        output hostWriteValid, hostWriteAddress, hostWriteData, memoryWriteComplete,
        input  hostWriteReady, memoryWriteRequest, memoryWriteAddress, memoryWriteData,
        input  queueLevel, queueEmpty
    );

    modport slave (
        input  hostWriteValid, hostWriteAddress, hostWriteData, memoryWriteComplete,
        output hostWriteReady, memoryWriteRequest, memoryWriteAddress, memoryWriteData,
        output queueLevel, queueEmpty
    );

endinterface

// File: rtl/memory_write_queue_fifo.sv
// -----------------------------------------------------------------------------
// write_queue_fifo
// Circular storage for queued writes: array, read/write pointers and level.
// Ports:
//   clock, reset       : system clock, synchronous active-high reset
//   push_i/push_entry_i: append one {addr, data} entry at the write pointer
//   pop_i              : drop the head entry
//   overwrite_i/overwrite_data_i/tail_addr_o : youngest-entry data overwrite
//                        and its address (only with WRITE_QUEUE_COALESCE_EN)
//   head_entry_o       : entry at the read pointer
//   level_o/full_o/empty_o : occupancy
// Optional feature macro: WRITE_QUEUE_COALESCE_EN
// -----------------------------------------------------------------------------
module write_queue_fifo
    import g76_memory_pkg::*;
#(
    parameter int  DEPTH       = 8,
    parameter int  ADDR_WIDTH  = g76_memory_pkg::ADDR_WIDTH,
    parameter int  DATA_WIDTH  = g76_memory_pkg::DATA_WIDTH,
    localparam int PTR_WIDTH   = $clog2(DEPTH),
    localparam int LVL_WIDTH   = PTR_WIDTH + 1,
    localparam int ENTRY_WIDTH = ADDR_WIDTH + DATA_WIDTH
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   push_i,
    input  logic [ENTRY_WIDTH-1:0] push_entry_i,
    input  logic                   pop_i,
`ifdef WRITE_QUEUE_COALESCE_EN
    input  logic                   overwrite_i,
    input  logic [DATA_WIDTH-1:0]  overwrite_data_i,
    output logic [ADDR_WIDTH-1:0]  tail_addr_o,
`endif
    output logic [ENTRY_WIDTH-1:0] head_entry_o,
    output logic [LVL_WIDTH-1:0]   level_o,
    output logic                   full_o,
    output logic                   empty_o
);

    logic [ENTRY_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_WIDTH-1:0]   wp_q, wp_d;
    logic [PTR_WIDTH-1:0]   rp_q, rp_d;
    logic [LVL_WIDTH-1:0]   level_q, level_d;

`ifdef WRITE_QUEUE_COALESCE_EN
    logic [PTR_WIDTH-1:0]   tail_idx_s;

    // Youngest entry sits one slot behind the write pointer (wraps naturally).
    always_comb begin
        tail_idx_s = wp_q - PTR_WIDTH'(1);
    end

    assign tail_addr_o = mem_q[tail_idx_s][ENTRY_WIDTH-1:DATA_WIDTH];
`endif

    // Next pointers and level; DEPTH is a power of two so pointers wrap for free.
    always_comb begin
        wp_d    = wp_q;
        rp_d    = rp_q;
        level_d = level_q;
        if (push_i) begin
            wp_d = wp_q + PTR_WIDTH'(1);
        end else begin
            wp_d = wp_q;
        end
        if (pop_i) begin
            rp_d = rp_q + PTR_WIDTH'(1);
        end else begin
            rp_d = rp_q;
        end
        case ({push_i, pop_i})
            2'b10:   level_d = level_q + LVL_WIDTH'(1);
            2'b01:   level_d = level_q - LVL_WIDTH'(1);
            default: level_d = level_q;
        endcase
    end

    // Pointer and level registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            wp_q    <= '0;
            rp_q    <= '0;
            level_q <= '0;
        end else begin
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            level_q <= level_d;
        end
    end

    // Entry storage; contents are don't-care until pushed, so no reset.
    always_ff @(posedge clock) begin
        if (push_i) begin
            mem_q[wp_q] <= push_entry_i;
        end
`ifdef WRITE_QUEUE_COALESCE_EN
        else if (overwrite_i) begin
            mem_q[tail_idx_s][DATA_WIDTH-1:0] <= overwrite_data_i;
        end
`endif
    end

    assign head_entry_o = mem_q[rp_q];
    assign level_o      = level_q;
    assign full_o       = (level_q == LVL_WIDTH'(DEPTH));
    assign empty_o      = (level_q == LVL_WIDTH'(0));

endmodule

// File: rtl/memory_write_queue.sv
// -----------------------------------------------------------------------------
// memory_write_queue
// Buffers host byte writes and issues them one at a time to the memory
// manager write port (request held until a one-cycle complete pulse).
// Ports:
//   clock : system clock, all logic on posedge
//   reset : synchronous, active-high; flushes the queue and drops the request
//   bus   : memory_write_queue_if.slave
//           host side   hostWriteValid/Address/Data in, hostWriteReady out
//           memory side memoryWriteRequest/Address/Data out,
//                       memoryWriteComplete in
//           status      queueLevel, queueEmpty
// Optional feature macro: WRITE_QUEUE_COALESCE_EN -- a push to the address of
// the youngest queued entry (not the in-flight head) overwrites its data.
// -----------------------------------------------------------------------------
module memory_write_queue
    import g76_memory_pkg::*;
#(
    parameter int  DEPTH       = 8,
    parameter int  ADDR_WIDTH  = g76_memory_pkg::ADDR_WIDTH,
    parameter int  DATA_WIDTH  = g76_memory_pkg::DATA_WIDTH,
    localparam int LVL_WIDTH   = $clog2(DEPTH) + 1,
    localparam int ENTRY_WIDTH = ADDR_WIDTH + DATA_WIDTH
) (
    input logic             clock,
    input logic             reset,
    memory_write_queue_if.slave bus
);

    write_queue_state_t     state_q, state_d;
    logic                   req_q, req_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [DATA_WIDTH-1:0]  data_q, data_d;

    logic [ENTRY_WIDTH-1:0] head_entry_s;
    logic [LVL_WIDTH-1:0]   level_s;
    logic                   full_s;
    logic                   empty_s;
    logic                   ready_s;
    logic                   push_s;
    logic                   pop_s;

`ifdef WRITE_QUEUE_COALESCE_EN
    logic                   coalesce_hit_s;
    logic                   overwrite_s;
    logic [ADDR_WIDTH-1:0]  tail_addr_s;
`endif

    write_queue_fifo #(
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_fifo (
        .clock            (clock),
        .reset            (reset),
        .push_i           (push_s),
        .push_entry_i     ({bus.hostWriteAddress, bus.hostWriteData}),
        .pop_i            (pop_s),
`ifdef WRITE_QUEUE_COALESCE_EN
        .overwrite_i      (overwrite_s),
        .overwrite_data_i (bus.hostWriteData),
        .tail_addr_o      (tail_addr_s),
`endif
        .head_entry_o     (head_entry_s),
        .level_o          (level_s),
        .full_o           (full_s),
        .empty_o          (empty_s)
    );

    // Host acceptance: ready depends only on the level register, so a pop in
    // the same cycle never frees a slot for a push into a full queue.
    always_comb begin
`ifdef WRITE_QUEUE_COALESCE_EN
        // With a single entry the youngest is the head, which is being issued
        // (IDLE latches it on this very edge), so it must not be modified.
        coalesce_hit_s = (level_s > LVL_WIDTH'(1)) &&
                         (tail_addr_s == bus.hostWriteAddress);
        ready_s        = !full_s || coalesce_hit_s;
        overwrite_s    = bus.hostWriteValid && coalesce_hit_s;
        push_s         = bus.hostWriteValid && !coalesce_hit_s && !full_s;
`else
        ready_s        = !full_s;
        push_s         = bus.hostWriteValid && ready_s;
`endif
    end

    // Issue FSM: latch head and raise request, wait for complete, then pop.
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        addr_d  = addr_q;
        data_d  = data_q;
        pop_s   = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty_s) begin
                    addr_d  = head_entry_s[ENTRY_WIDTH-1:DATA_WIDTH];
                    data_d  = head_entry_s[DATA_WIDTH-1:0];
                    req_d   = 1'b1;
                    state_d = ISSUE;
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                if (bus.memoryWriteComplete) begin
                    req_d   = 1'b0;
                    state_d = RETIRE;
                end else begin
                    state_d = ISSUE;
                end
            end
            RETIRE: begin
                pop_s   = 1'b1;
                state_d = IDLE;
            end
            default: begin
                req_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // FSM state and registered memory-port outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    assign bus.hostWriteReady     = ready_s;
    assign bus.memoryWriteRequest = req_q;
    assign bus.memoryWriteAddress = addr_q;
    assign bus.memoryWriteData    = data_q;
    assign bus.queueLevel         = level_s;
    assign bus.queueEmpty         = empty_s;

endmodule

// File: tb/tb_memory_write_queue.sv
// -----------------------------------------------------------------------------
// tb_memory_write_queue
// Self-checking bench for memory_write_queue. A queue-based reference model
// predicts level, ready and the memory-port outputs every cycle; a second
// in-order list of accepted writes is compared against what the memory port
// presents at each complete pulse.
// -----------------------------------------------------------------------------
module tb_memory_write_queue;
    import g76_memory_pkg::*;

    localparam int DEPTH = 8;
`ifdef WRITE_QUEUE_COALESCE_EN
    localparam bit COALESCE_ON = 1'b1;
`else
    localparam bit COALESCE_ON = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    memory_write_queue_if #(.DEPTH(DEPTH)) bus ();

    memory_write_queue #(.DEPTH(DEPTH)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    // reference model state
    write_entry_t mq[$];       // entries still occupying the queue
    write_entry_t golden[$];   // accepted writes not yet completed
    bit           m_req    = 1'b0;
    bit           m_retire = 1'b0;
    write_entry_t m_out    = '0;
    int           mem_wait = 0;
    int           issued   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic bit coalesce_hit(input logic [ADDR_WIDTH-1:0] a);
        if (mq.size() < 2) return 1'b0;
        return COALESCE_ON && (mq[mq.size()-1].addr == a);
    endfunction

    // memory manager model: random latency, optional stray pulses
    function automatic bit mem_complete(input bit allow_stray);
        if (m_req) begin
            if (mem_wait == 0) begin
                mem_wait = $urandom_range(0, 3);
                return 1'b1;
            end
            mem_wait--;
            return 1'b0;
        end
        return allow_stray && ($urandom_range(0, 7) == 0);
    endfunction

    task automatic check_outputs();
        bit exp_ready;
        exp_ready = (mq.size() < DEPTH) || coalesce_hit(bus.hostWriteAddress);
        check_eq("level",   32'(bus.queueLevel),         32'(mq.size()));
        check_eq("empty",   32'(bus.queueEmpty),         32'(mq.size() == 0));
        check_eq("ready",   32'(bus.hostWriteReady),     32'(exp_ready));
        check_eq("request", 32'(bus.memoryWriteRequest), 32'(m_req));
        check_eq("addr",    32'(bus.memoryWriteAddress), 32'(m_out.addr));
        check_eq("data",    32'(bus.memoryWriteData),    32'(m_out.data));
    endtask

    // One clock cycle: drive at negedge, update model at posedge, check at next negedge.
    task automatic step(input bit v, input logic [ADDR_WIDTH-1:0] a,
                        input logic [DATA_WIDTH-1:0] d, input bit c, input bit rst);
        logic [ADDR_WIDTH-1:0] obs_a;
        logic [DATA_WIDTH-1:0] obs_d;
        bit acc, hit, nreq, nret;
        write_entry_t e, g;
        bus.hostWriteValid      = v;
        bus.hostWriteAddress    = a;
        bus.hostWriteData       = d;
        bus.memoryWriteComplete = c;
        reset                   = rst;
        #1;
        obs_a = bus.memoryWriteAddress;
        obs_d = bus.memoryWriteData;
        @(posedge clock);
        if (rst) begin
            mq.delete();
            golden.delete();
            m_req    = 1'b0;
            m_retire = 1'b0;
            m_out    = '0;
        end else begin
            hit  = coalesce_hit(a);
            acc  = v && ((mq.size() < DEPTH) || hit);
            nreq = m_req;
            nret = 1'b0;
            if (m_req) begin
                if (c) begin
                    nreq = 1'b0;
                    nret = 1'b1;
                    if (golden.size() > 0) begin
                        g = golden.pop_front();
                        issued++;
                        check_eq("issue_addr", 32'(obs_a), 32'(g.addr));
                        check_eq("issue_data", 32'(obs_d), 32'(g.data));
                    end else begin
                        check_eq("issue_pending", 32'(golden.size()), 32'd1);
                    end
                end
            end else if (!m_retire && mq.size() != 0) begin
                nreq  = 1'b1;
                m_out = mq[0];
            end
            if (m_retire) void'(mq.pop_front());
            if (acc) begin
                if (hit) begin
                    e = mq[mq.size()-1];
                    e.data = d;
                    mq[mq.size()-1] = e;
                    e = golden[golden.size()-1];
                    e.data = d;
                    golden[golden.size()-1] = e;
                end else begin
                    e.addr = a;
                    e.data = d;
                    mq.push_back(e);
                    golden.push_back(e);
                end
            end
            m_req    = nreq;
            m_retire = nret;
        end
        @(negedge clock);
        check_outputs();
    endtask

    task automatic idle(input int n, input bit stall);
        for (int i = 0; i < n; i++) begin
            step(1'b0, '0, '0, stall ? 1'b0 : mem_complete(1'b0), 1'b0);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 400 && mq.size() != 0; i++) begin
            step(1'b0, '0, '0, mem_complete(1'b0), 1'b0);
        end
        check_eq("drained_model", 32'(mq.size()), 32'd0);
        check_eq("drained_level", 32'(bus.queueLevel), 32'd0);
    endtask

    initial begin
        int pushed;
        int issued_before;
        bus.hostWriteValid      = 1'b0;
        bus.hostWriteAddress    = '0;
        bus.hostWriteData       = '0;
        bus.memoryWriteComplete = 1'b0;
        @(negedge clock);

        // reset state
        step(1'b0, '0, '0, 1'b0, 1'b1);
        step(1'b0, '0, '0, 1'b0, 1'b1);
        check_eq("rst_req",   32'(bus.memoryWriteRequest), 32'd0);
        check_eq("rst_level", 32'(bus.queueLevel),         32'd0);
        check_eq("rst_empty", 32'(bus.queueEmpty),         32'd1);
        check_eq("rst_ready", 32'(bus.hostWriteReady),     32'd1);
        check_eq("rst_addr",  32'(bus.memoryWriteAddress), 32'd0);
        idle(1, 1'b1);

        // single write: request two cycles after the push
        step(1'b1, 17'h00123, 8'hA5, 1'b0, 1'b0);
        check_eq("sw_level1", 32'(bus.queueLevel),         32'd1);
        check_eq("sw_req_n1", 32'(bus.memoryWriteRequest), 32'd0);
        idle(1, 1'b1);
        check_eq("sw_req_n2", 32'(bus.memoryWriteRequest), 32'd1);
        check_eq("sw_addr",   32'(bus.memoryWriteAddress), 32'h00123);
        check_eq("sw_data",   32'(bus.memoryWriteData),    32'hA5);
        idle(2, 1'b1);
        check_eq("sw_hold",   32'(bus.memoryWriteAddress), 32'h00123);
        step(1'b0, '0, '0, 1'b1, 1'b0);
        check_eq("sw_req_drop", 32'(bus.memoryWriteRequest), 32'd0);
        check_eq("sw_level_rt", 32'(bus.queueLevel),         32'd1);
        idle(1, 1'b1);
        check_eq("sw_level0",   32'(bus.queueLevel),         32'd0);

        // stray complete in IDLE
        step(1'b0, '0, '0, 1'b1, 1'b0);
        check_eq("stray_level", 32'(bus.queueLevel),         32'd0);
        check_eq("stray_req",   32'(bus.memoryWriteRequest), 32'd0);

        // fill with completes stalled, then a rejected ninth push
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, 17'(32'h100 + i), 8'(i + 1), 1'b0, 1'b0);
        end
        check_eq("fill_level", 32'(bus.queueLevel),     32'd8);
        check_eq("fill_ready", 32'(bus.hostWriteReady), 32'd0);
        step(1'b1, 17'h001FF, 8'hEE, 1'b0, 1'b0);
        check_eq("fill_reject", 32'(bus.queueLevel),    32'd8);
        drain();

        // push in the same cycle as the RETIRE pop
        step(1'b1, 17'h00200, 8'h01, 1'b0, 1'b0);
        idle(1, 1'b1);
        step(1'b0, '0, '0, 1'b1, 1'b0);
        step(1'b1, 17'h00201, 8'h02, 1'b0, 1'b0);
        check_eq("push_pop_level", 32'(bus.queueLevel), 32'd1);
        drain();

        // same-address pushes behind an in-flight head
        step(1'b1, 17'h00300, 8'h33, 1'b0, 1'b0);
        idle(1, 1'b1);
        step(1'b1, 17'h00010, 8'h11, 1'b0, 1'b0);
        step(1'b1, 17'h00010, 8'h22, 1'b0, 1'b0);
        check_eq("coalesce_level", 32'(bus.queueLevel), COALESCE_ON ? 32'd2 : 32'd3);
        drain();

        // reset while a write is in ISSUE; later complete is ignored
        step(1'b1, 17'h00400, 8'h44, 1'b0, 1'b0);
        idle(2, 1'b1);
        step(1'b0, '0, '0, 1'b0, 1'b1);
        check_eq("rst_mid_req",   32'(bus.memoryWriteRequest), 32'd0);
        check_eq("rst_mid_level", 32'(bus.queueLevel),         32'd0);
        step(1'b0, '0, '0, 1'b1, 1'b0);
        check_eq("rst_late_cmpl", 32'(bus.queueLevel),         32'd0);
        idle(1, 1'b1);

        // twenty writes interleaved with completes (pointers wrap twice)
        issued_before = issued;
        pushed = 0;
        for (int i = 0; i < 400 && pushed < 20; i++) begin
            if (mq.size() < DEPTH) pushed++;
            step(1'b1, 17'(32'h500 + pushed), 8'(pushed * 7), mem_complete(1'b0), 1'b0);
        end
        drain();
        check_eq("wrap_count", 32'(issued - issued_before), 32'd20);

        // randomized traffic with stray completes and occasional resets
        for (int i = 0; i < 3000; i++) begin
            step(1'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) == 0) ? 17'($urandom) : 17'($urandom_range(0, 3)),
                 8'($urandom),
                 mem_complete(1'b1),
                 $urandom_range(0, 299) == 0);
        end
        drain();
        check_eq("final_pending", 32'(golden.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
